// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default widths.
package counter_sequencer_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_sequencer_prescaler_tick.sv
// Prescaler: counts 0..limit while run is high and flags the cycle on which it wraps.
module prescaler_tick #(
    parameter int PRE_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [PRE_W-1:0] limit,
    output logic             step
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Combinational: step is registered by the parent together with the count update.
    assign step = run && !clear && (cnt_q == limit);

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == limit) ? '0 : cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Programmable interval timer: start latches period/prescale/mode, the counter
// advances on prescaled steps, and tick/done report terminal count.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic             busy,
    output logic             step,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_l_q, period_l_d;
    logic [PRE_W-1:0] prescale_l_q, prescale_l_d;
    logic             periodic_l_q, periodic_l_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic start_ok;
    logic start_bad;
    logic in_run;
    logic pre_step;
    logic at_term;

    // A start coinciding with stop is dropped entirely, including the zero-period error.
    assign start_ok  = start && !stop && (period != '0);
    assign start_bad = start && !stop && (period == '0);
    assign in_run    = (state_q == RUN);
    assign at_term   = (count_q == period_l_q);

    prescaler_tick #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok && !in_run),
        .run   (in_run && !stop),
        .limit (prescale_l_q),
        .step  (pre_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pre_step && at_term && !periodic_l_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start_ok) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        period_l_d   = period_l_q;
        prescale_l_d = prescale_l_q;
        periodic_l_d = periodic_l_q;
        step_d       = 1'b0;
        tick_d       = 1'b0;
        err_d        = 1'b0;
        done_d       = done_q;
        busy_d       = (state_d == RUN);

        if (in_run) begin
            if (!stop && pre_step) begin
                step_d = 1'b1;
                if (at_term) begin
                    tick_d = 1'b1;
                    if (periodic_l_q) begin
                        count_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end else begin
            if (stop) begin
                done_d = 1'b0;
            end else if (start_ok) begin
                period_l_d   = period;
                prescale_l_d = prescale;
                periodic_l_d = periodic;
                count_d      = '0;
                done_d       = 1'b0;
            end else if (start_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            period_l_q   <= '0;
            prescale_l_q <= '0;
            periodic_l_q <= 1'b0;
            busy_q       <= 1'b0;
            step_q       <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            period_l_q   <= period_l_d;
            prescale_l_q <= prescale_l_d;
            periodic_l_q <= periodic_l_d;
            busy_q       <= busy_d;
            step_q       <= step_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign busy  = busy_q;
    assign step  = step_q;
    assign count = count_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: expected outputs come from closed-form
// timing formulas, queued at drive time and compared after each clock edge.
module tb_counter_sequencer;

    typedef struct packed {
        logic       busy;
        logic       step;
        logic [3:0] count;
        logic       tick;
        logic       done;
        logic       err;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [3:0] period;
    logic [1:0] prescale;
    logic       busy, step, tick, done, err;
    logic [3:0] count;
    out_t       obs;
    out_t       exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .prescale (prescale),
        .busy     (busy),
        .step     (step),
        .count    (count),
        .tick     (tick),
        .done     (done),
        .err      (err)
    );

    assign obs = '{busy: busy, step: step, count: count, tick: tick, done: done, err: err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (busy,step,count,tick,done,err)", tag, got, want);
        end
    endtask

    function automatic out_t mk(bit b, bit s, int c, bit t, bit d, bit e);
        out_t o;
        o.busy  = b;
        o.step  = s;
        o.count = 4'(c);
        o.tick  = t;
        o.done  = d;
        o.err   = e;
        return o;
    endfunction

    // Expected outputs n edges after a start accepted at edge 0.
    function automatic out_t exp_at(int n, int pp, int ps, bit m);
        int  s   = n / (ps + 1);
        bit  stp = (n > 0) && (n % (ps + 1) == 0);
        int  t   = (pp + 1) * (ps + 1);
        if (m) return mk(1, stp, s % (pp + 1), stp && (s % (pp + 1) == 0), 0, 0);
        if (n < t)  return mk(1, stp, s, 0, 0, 0);
        if (n == t) return mk(0, 1, pp, 1, 1, 0);
        return mk(0, 0, pp, 0, 1, 0);
    endfunction

    task automatic edge_chk(input string tag, input out_t want);
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        check(tag, 32'(obs), 32'(exp_q.pop_front()));
    endtask

    // Start a run at edge 0, then scramble the config inputs (and retry start once)
    // so that any re-latching during RUN shows up as a count/tick error.
    task automatic run_seq(input string tag, input int pp, input int ps, input bit m, input int n_edges);
        for (int n = 0; n < n_edges; n++) begin
            if (n == 0) begin
                start    = 1'b1;
                period   = 4'(pp);
                prescale = 2'(ps);
                periodic = m;
            end else begin
                start    = (n == 1);
                period   = 4'($urandom);
                prescale = 2'($urandom);
                periodic = ~m;
            end
            edge_chk($sformatf("%s_e%0d", tag, n), exp_at(n, pp, ps, m));
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        period   = '0;
        prescale = '0;
        #12;
        check("reset", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0)));
        reset = 1'b0;

        run_seq("oneshot", 3, 0, 1'b0, 8);

        // Periodic run started from DONE, then stopped.
        run_seq("periodic", 2, 1, 1'b1, 20);
        stop = 1'b1;
        edge_chk("periodic_stop", mk(0, 0, 0, 0, 0, 0));
        stop = 1'b0;

        // Stop on the terminal-count edge: no tick, count frozen at period.
        run_seq("stopterm", 2, 0, 1'b1, 3);
        stop = 1'b1;
        edge_chk("stopterm_edge", mk(0, 0, 2, 0, 0, 0));
        stop = 1'b0;
        edge_chk("stopterm_idle1", mk(0, 0, 2, 0, 0, 0));
        edge_chk("stopterm_idle2", mk(0, 0, 2, 0, 0, 0));

        // Zero-period start is rejected with a single err pulse.
        start  = 1'b1;
        period = '0;
        edge_chk("reject_err", mk(0, 0, 2, 0, 0, 1));
        start  = 1'b0;
        period = 4'd5;
        edge_chk("reject_after", mk(0, 0, 2, 0, 0, 0));
        start = 1'b1;
        stop  = 1'b1;
        edge_chk("startstop_idle", mk(0, 0, 2, 0, 0, 0));
        start = 1'b0;
        stop  = 1'b0;
        edge_chk("startstop_after", mk(0, 0, 2, 0, 0, 0));

        // Asynchronous reset between edges while running at count 2.
        run_seq("pre_reset", 5, 0, 1'b0, 3);
        #1 reset = 1'b1;
        #1 check("async_reset", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0)));
        #1 reset = 1'b0;
        run_seq("post_reset", 2, 1, 1'b0, 9);

        // Restart from DONE at the largest legal period.
        check("done_before_restart", 32'(obs), 32'(mk(0, 0, 2, 0, 1, 0)));
        run_seq("max_period", 15, 0, 1'b0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that sequences a WIDTH-bit binary up-counter as a programmable interval timer. A start pulse latches the period, prescale and mode, then the counter advances under a prescaled enable. A one-cycle tick is raised at each terminal count. The block is used as the timing engine in front of any logic that previously drove a free-running counter's enable by hand.

Parameters:
WIDTH, 4, width of the counter, period and count.
PRE_W, 2, width of the prescale field; a count step occurs every prescale+1 clocks.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a run; samples period, prescale and periodic.
stop  input  1  one-cycle abort request; has priority over everything else.
periodic  input  1  sampled at start. 1 = auto-reload, 0 = one-shot.
period  input  WIDTH  terminal count value; must be nonzero.
prescale  input  PRE_W  clocks per count step, minus 1.
busy  output  1  high while in RUN.
step  output  1  internal enable to the counter; one cycle per count advance.
count  output  WIDTH  current counter value.
tick  output  1  one-cycle pulse at each terminal count.
done  output  1  one-shot run completed; level output.
err  output  1  one-cycle pulse when start is rejected because period==0.

Behaviour:
- Reset (async, any state): state=IDLE, count=0, prescaler=0, latched regs=0; busy, step, tick, done and err all 0.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - start=1, stop=0, period!=0: latch period_l, prescale_l and periodic_l. Clear count and prescaler. Next state is RUN, with busy=1 after the edge.
  - start=1 with period==0: err=1 for one cycle and stay IDLE.
  - start=1 with stop=1: start is ignored.
- RUN:
  - The prescaler counts 0..prescale_l. On the cycle it equals prescale_l it wraps to 0 and step=1.
  - On a step with count!=period_l: count increments by 1.
  - On a step with count==period_l: tick=1 for one cycle.
    - periodic_l=1: count returns to 0 and the block stays in RUN.
    - periodic_l=0: count holds at period_l, next state is DONE, busy=0 and done=1.
  - stop=1: next state is IDLE, busy=0, and count and prescaler freeze. No tick or step is issued on that edge, including when the edge coincides with terminal count.
  - start is ignored during RUN; inputs are not re-latched.
- DONE:
  - done stays high.
  - start behaves as in IDLE, clears done, and begins a new run.
  - stop clears done and moves to IDLE.
- Timing with prescale=p and period=P:
  - start at edge 0 gives count=k at edge k*(p+1).
  - tick is at edge (P+1)*(p+1); in one-shot mode done rises on that same edge.
  - Periodic tick interval is (P+1)*(p+1) clocks.
- Arithmetic is unsigned modulo 2^WIDTH. period=2^WIDTH-1 is legal, and count never exceeds period_l.
- Changes to period, prescale or periodic during RUN have no effect.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH and PRE_W constants.
- One natural sub-module is prescaler_tick. It takes clk, reset, clear, run and limit[PRE_W] and produces a step pulse.
- The FSM and the counter stay in counter_sequencer.

Test Plan:
- One-shot: period=3, prescale=0, start at edge 0 → count 1,2,3 at edges 1-3; tick=1, done=1, busy=0 at edge 4; count holds 3.
- Periodic with prescale: period=2, prescale=1, periodic=1 → count advances every 2 clocks; tick at edges 6, 12 and 18; busy stays 1.
- Stop at terminal edge: periodic run with stop asserted on the cycle count==period and step=1 → no tick, state IDLE, count frozen at period.
- Rejected start: period=0 with start → err pulses once, busy stays 0, count unchanged. A start/stop coincidence in IDLE produces no run.
- Async reset mid-RUN at count=2: outputs go to 0 without waiting for a clock edge. The next start runs normally from count=0.
- Restart from DONE: after a one-shot, a new start with period=15 clears done and runs to count=15 with a single tick, confirming the upper boundary.
